// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI output path.
//
// Two free-running position counters walk the same raster:
//   - the lead counter drives the pixel-fetch request (req, req_x, req_y);
//   - the display counter trails it by REQ_LEAD positions and drives the
//     video controls (de, hsync, vsync, x, y, frame_start).
// An upstream frame-buffer reader with a fixed latency of REQ_LEAD cycles
// therefore returns pixel data exactly in the cycle de is asserted for it.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   de           active video
//   hsync        horizontal sync, active level HS_POL
//   vsync        vertical sync, active level VS_POL (whole lines)
//   x, y         display position inside the active area, 0 outside it
//   frame_start  single-cycle pulse with de at position (0,0)
//   req          fetch request for pixel (req_x, req_y)
//   req_x, req_y requested position, 0 when req is low
//
// Line layout: active, front porch, sync, back porch. Frames use the same
// order counted in lines. All raster totals must fit in 12 bits, and
// REQ_LEAD must lie in 1..(H_FP+H_SYNC+H_BP).

module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned REQ_LEAD = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        req,
  output logic [11:0] req_x,
  output logic [11:0] req_y
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  // The display counter starts REQ_LEAD positions before (0,0), i.e. in the
  // horizontal blanking of the last frame line, so no partial frame is shown.
  localparam logic [11:0] DISP_H_INIT = 12'(H_TOTAL - REQ_LEAD);
  localparam logic [11:0] DISP_V_INIT = V_LAST;

  // Position counters
  logic [11:0] lead_h_q, lead_h_d;
  logic [11:0] lead_v_q, lead_v_d;
  logic [11:0] disp_h_q, disp_h_d;
  logic [11:0] disp_v_q, disp_v_d;

  // Registered outputs
  logic        de_q;
  logic        hsync_q;
  logic        vsync_q;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic        frame_start_q;
  logic        req_q;
  logic [11:0] req_x_q;
  logic [11:0] req_y_q;

  // Decodes of the current (pre-edge) counter values
  logic lead_active;
  logic disp_active;
  logic disp_hs_on;
  logic disp_vs_on;
  logic disp_origin;

  // Next-state for both counters: h wraps at H_LAST and carries into v.
  always_comb begin
    lead_h_d = lead_h_q + 12'd1;
    lead_v_d = lead_v_q;
    if (lead_h_q == H_LAST) begin
      lead_h_d = '0;
      lead_v_d = (lead_v_q == V_LAST) ? '0 : lead_v_q + 12'd1;
    end

    disp_h_d = disp_h_q + 12'd1;
    disp_v_d = disp_v_q;
    if (disp_h_q == H_LAST) begin
      disp_h_d = '0;
      disp_v_d = (disp_v_q == V_LAST) ? '0 : disp_v_q + 12'd1;
    end
  end

  always_comb begin
    lead_active = (lead_h_q < H_ACT) && (lead_v_q < V_ACT);
    disp_active = (disp_h_q < H_ACT) && (disp_v_q < V_ACT);
    disp_hs_on  = (disp_h_q >= HS_START) && (disp_h_q < HS_END);
    disp_vs_on  = (disp_v_q >= VS_START) && (disp_v_q < VS_END);
    disp_origin = (disp_h_q == '0) && (disp_v_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lead_h_q      <= '0;
      lead_v_q      <= '0;
      disp_h_q      <= DISP_H_INIT;
      disp_v_q      <= DISP_V_INIT;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      req_q         <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
    end else begin
      lead_h_q      <= lead_h_d;
      lead_v_q      <= lead_v_d;
      disp_h_q      <= disp_h_d;
      disp_v_q      <= disp_v_d;
      de_q          <= disp_active;
      hsync_q       <= disp_hs_on ? HS_POL : ~HS_POL;
      vsync_q       <= disp_vs_on ? VS_POL : ~VS_POL;
      x_q           <= disp_active ? disp_h_q : '0;
      y_q           <= disp_active ? disp_v_q : '0;
      frame_start_q <= disp_active && disp_origin;
      req_q         <= lead_active;
      req_x_q       <= lead_active ? lead_h_q : '0;
      req_y_q       <= lead_active ? lead_v_q : '0;
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign req         = req_q;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Three instances share one clock:
//   dut_d - default parameters (reset/release sequence, one full line)
//   dut_a - default line timing, short frame of 30 lines (frame-level checks,
//           req/de pairing, mid-frame reset)
//   dut_b - tiny raster with positive syncs and REQ_LEAD=3 (every cycle)
// Each instance has a reference model that pushes the expected outputs for
// every edge into a queue; a monitor pops and compares on the falling edge.
module tb_video_timing_gen;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        req;
    logic [11:0] rx;
    logic [11:0] ry;
  } vt_t;

  typedef struct {
    int x;
    int y;
    int t;
  } rq_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  int ncyc = 0;
  initial forever begin
    @(posedge clk);
    ncyc++;
  end

  // ---------------- DUT signals ----------------
  logic rst_a = 1'b1, rst_b = 1'b1, rst_d = 1'b1;
  logic de_a, hs_a, vs_a, fs_a, rq_a;
  logic de_b, hs_b, vs_b, fs_b, rq_b;
  logic de_d, hs_d, vs_d, fs_d, rq_d;
  logic [11:0] px_a, py_a, rqx_a, rqy_a;
  logic [11:0] px_b, py_b, rqx_b, rqy_b;
  logic [11:0] px_d, py_d, rqx_d, rqy_d;

  video_timing_gen #(
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_a (
    .clk(clk), .rst(rst_a), .de(de_a), .hsync(hs_a), .vsync(vs_a), .x(px_a), .y(py_a),
    .frame_start(fs_a), .req(rq_a), .req_x(rqx_a), .req_y(rqy_a)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .de(de_b), .hsync(hs_b), .vsync(vs_b), .x(px_b), .y(py_b),
    .frame_start(fs_b), .req(rq_b), .req_x(rqx_b), .req_y(rqy_b)
  );

  video_timing_gen dut_d (
    .clk(clk), .rst(rst_d), .de(de_d), .hsync(hs_d), .vsync(vs_d), .x(px_d), .y(py_d),
    .frame_start(fs_d), .req(rq_d), .req_x(rqx_d), .req_y(rqy_d)
  );

  vt_t act_a, act_b, act_d;
  assign act_a = {de_a, hs_a, vs_a, px_a, py_a, fs_a, rq_a, rqx_a, rqy_a};
  assign act_b = {de_b, hs_b, vs_b, px_b, py_b, fs_b, rq_b, rqx_b, rqy_b};
  assign act_d = {de_d, hs_d, vs_d, px_d, py_d, fs_d, rq_d, rqx_d, rqy_d};

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vt(input string name, input vt_t act, input vt_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got de=%b hs=%b vs=%b x=%0d y=%0d fs=%b req=%b rx=%0d ry=%0d, expected de=%b hs=%b vs=%b x=%0d y=%0d fs=%b req=%b rx=%0d ry=%0d (t=%0t)",
               name, act.de, act.hs, act.vs, act.x, act.y, act.fs, act.req, act.rx, act.ry,
               exp.de, exp.hs, exp.vs, exp.x, exp.y, exp.fs, exp.req, exp.rx, exp.ry, $time);
    end
  endtask

  // Expected outputs after the k-th edge since reset release (k = 0: in reset).
  // Positions are handled as a linear index into the frame.
  function automatic vt_t model(input int ha, input int hf, input int hsw, input int hb,
                                input int va, input int vf, input int vsw, input int vb,
                                input bit hp, input bit vp, input int lead, input int k);
    vt_t e;
    int ht, vt, fr, p, d, lh, lv, h, v;
    e    = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    if (k == 0) return e;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    fr = ht * vt;
    p  = (k - 1) % fr;
    lh = p % ht;
    lv = p / ht;
    if (lh < ha && lv < va) begin
      e.req = 1'b1;
      e.rx  = 12'(lh);
      e.ry  = 12'(lv);
    end
    d = (p - lead + fr) % fr;
    h = d % ht;
    v = d / ht;
    if (h < ha && v < va) begin
      e.de = 1'b1;
      e.x  = 12'(h);
      e.y  = 12'(v);
    end
    e.fs = (d == 0);
    e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    e.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    return e;
  endfunction

  // ---------------- model (producer) processes ----------------
  int  k_a = 0, k_b = 0, k_d = 0;
  vt_t q_a[$], q_b[$], q_d[$];

  initial forever begin
    @(posedge clk);
    k_a = rst_a ? 0 : k_a + 1;
    k_b = rst_b ? 0 : k_b + 1;
    k_d = rst_d ? 0 : k_d + 1;
    q_a.push_back(model(640, 16, 96, 48, 24, 2, 2, 2, 1'b0, 1'b0, 2, k_a));
    q_b.push_back(model(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1, 3, k_b));
    q_d.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, k_d));
  end

  // ---------------- monitors (consumers) ----------------
  initial forever begin
    @(negedge clk);
    if (q_a.size() != 0) chk_vt("cycle_a", act_a, q_a.pop_front());
    if (q_b.size() != 0) chk_vt("cycle_b", act_b, q_b.pop_front());
    if (q_d.size() != 0) chk_vt("cycle_d", act_d, q_d.pop_front());
  end

  // req/de pairing on dut_a: each req must reappear on de two cycles later.
  rq_t lq[$];
  rq_t r;
  initial forever begin
    @(negedge clk);
    if (k_a == 0) begin
      lq.delete();
    end else begin
      if (rq_a) lq.push_back(rq_t'{int'(rqx_a), int'(rqy_a), ncyc});
      if (de_a) begin
        chk("lead_pending", lq.size() > 0, 1);
        if (lq.size() > 0) begin
          r = lq.pop_front();
          chk("lead_x", px_a, r.x);
          chk("lead_y", py_a, r.y);
          chk("lead_delay", ncyc - r.t, 2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got t=%0t expected < 2000000", $time);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  int n_de, n_blank, n_hs, first_hs, last_hs;
  logic [11:0] x639, x640;
  int fs_first, fs_second, n_de_a, n_de_blank, n_vs, vs_first;
  int h, ln;

  initial begin
    // Reset held for 5 edges
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst_de", de_d, 0);
      chk("rst_hsync", hs_d, 1);
      chk("rst_vsync", vs_d, 1);
      chk("rst_req", rq_d, 0);
      chk("rst_fs", fs_d, 0);
      if (i < 4) @(negedge clk);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_d = 1'b0;

    @(negedge clk);
    chk("e1_req", rq_d, 1);
    chk("e1_req_x", rqx_d, 0);
    chk("e1_req_y", rqy_d, 0);
    chk("e1_de", de_d, 0);
    @(negedge clk);
    chk("e2_de", de_d, 0);
    chk("e2_req_x", rqx_d, 1);
    @(negedge clk);
    chk("e3_de", de_d, 1);
    chk("e3_x", px_d, 0);
    chk("e3_y", py_d, 0);
    chk("e3_fs", fs_d, 1);
    chk("e3_req_x", rqx_d, 2);

    fork
      // One full line on defaults
      begin
        n_de = 0; n_blank = 0; n_hs = 0; first_hs = -1; last_hs = -1;
        for (int c = 0; c < 800; c++) begin
          if (c > 0) @(negedge clk);
          if (de_d) n_de++;
          else n_blank++;
          if (!hs_d) begin
            n_hs++;
            if (first_hs < 0) first_hs = c;
            last_hs = c;
          end
          if (c == 639) x639 = px_d;
          if (c == 640) x640 = px_d;
        end
        chk("line_de", n_de, 640);
        chk("line_blank", n_blank, 160);
        chk("line_hs_low", n_hs, 96);
        chk("line_hs_first", first_hs, 656);
        chk("line_hs_last", last_hs, 751);
        chk("line_x_last", x639, 639);
        chk("line_x_after", x640, 0);
      end
      // Full short frame, then mid-frame reset on dut_a
      begin
        fs_first = -1; fs_second = -1; n_de_a = 0; n_de_blank = 0; n_vs = 0; vs_first = -1;
        for (int c = 0; c <= 24000; c++) begin
          if (c > 0) @(negedge clk);
          if (fs_a) begin
            if (fs_first < 0) fs_first = c;
            else if (fs_second < 0) fs_second = c;
          end
          if (c < 24000) begin
            if (de_a) n_de_a++;
            if (c >= 19200 && de_a) n_de_blank++;
            if (!vs_a) begin
              n_vs++;
              if (vs_first < 0) vs_first = c;
            end
          end
        end
        chk("frame_fs_first", fs_first, 0);
        chk("frame_fs_period", fs_second - fs_first, 24000);
        chk("frame_de", n_de_a, 15360);
        chk("frame_de_blank_lines", n_de_blank, 0);
        chk("frame_vs_low", n_vs, 1600);
        chk("frame_vs_first", vs_first, 20800);

        repeat (16300) @(negedge clk);
        chk("mid_x", px_a, 300);
        chk("mid_y", py_a, 20);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("mrst_de", de_a, 0);
        chk("mrst_hsync", hs_a, 1);
        chk("mrst_vsync", vs_a, 1);
        chk("mrst_req", rq_a, 0);
        @(negedge clk);
        chk("mr_e1_req", rq_a, 1);
        chk("mr_e1_req_x", rqx_a, 0);
        chk("mr_e1_req_y", rqy_a, 0);
        chk("mr_e1_de", de_a, 0);
        @(negedge clk);
        chk("mr_e2_de", de_a, 0);
        @(negedge clk);
        chk("mr_e3_de", de_a, 1);
        chk("mr_e3_x", px_a, 0);
        chk("mr_e3_y", py_a, 0);
        chk("mr_e3_fs", fs_a, 1);
      end
      // Tiny raster: three frames, 7x5 positions each
      begin
        @(negedge clk);
        chk("b_first_fs", fs_b, 1);
        for (int c = 0; c < 105; c++) begin
          if (c > 0) @(negedge clk);
          h  = c % 7;
          ln = (c / 7) % 5;
          chk("b_hsync", hs_b, (h == 5) ? 1 : 0);
          chk("b_vsync", vs_b, (ln == 3) ? 1 : 0);
          chk("b_de", de_b, (h < 4 && ln < 2) ? 1 : 0);
        end
      end
    join

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI output path: de, hsync and vsync feed the three tmds_encoder instances (DE on all channels; hsync→C0 and vsync→C1 on the blue channel).
- Also issues a pixel-fetch request REQ_LEAD cycles ahead of de, so an upstream frame-buffer reader with fixed latency REQ_LEAD delivers pixel data aligned with de.
- Single clock domain, the pixel clock.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- REQ_LEAD, 2, cycles by which req leads de; legal range 1..H_FP+H_SYNC+H_BP

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- de  output  1  active video
- hsync  output  1  horizontal sync, level per HS_POL
- vsync  output  1  vertical sync, level per VS_POL
- x  output  12  column of current output position; 0 outside active
- y  output  12  line of current output position; 0 outside active
- frame_start  output  1  one-cycle pulse when de is high at (0,0)
- req  output  1  fetch request for pixel (req_x, req_y)
- req_x  output  12  column requested; 0 when req low
- req_y  output  12  line requested; 0 when req low

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, front porch, sync, back porch. Frame order is the same, in lines.
- Position (h,v): h in 0..H_TOTAL-1, v in 0..V_TOTAL-1. h wraps to 0 and v increments at h = H_TOTAL-1; v wraps to 0 at V_TOTAL-1.
- Two position counters:
  - lead counter: drives req/req_x/req_y.
  - display counter: drives de/hsync/vsync/x/y/frame_start.
  - The display counter is always exactly REQ_LEAD positions behind the lead counter, with wrap across line and frame.
- Active region: h < H_ACTIVE and v < V_ACTIVE.
- hsync is active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, on any line, including vertical blanking.
- vsync is active when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, over whole lines (changes at h = 0).
- All outputs are registered. Outputs in a cycle reflect the counter values from before that edge; counters advance on the same edge.
- Reset (rst high at an edge):
  - lead counter → (0,0).
  - display counter → (H_TOTAL-REQ_LEAD, V_TOTAL-1).
  - Outputs: de=0, req=0, frame_start=0; x, y, req_x, req_y = 0; hsync = !HS_POL, vsync = !VS_POL.
- After rst release:
  - First edge: req=1 with req_x=0, req_y=0.
  - Edge REQ_LEAD+1: de=1, x=0, y=0, frame_start=1.
  - No partial first frame occurs.
- Reset asserted mid-frame: on the next edge, outputs go to their reset values and counters reload. The sequence restarts exactly as after power-up; no stale req or de remains.
- req is high for exactly H_ACTIVE×V_ACTIVE cycles per frame; de likewise.
- The k-th req is paired with the k-th de cycle (same coordinates), REQ_LEAD cycles later.
- frame_start and de at (0,0) coincide. frame_start never pulses more than once per V_TOTAL×H_TOTAL cycles.
- Counter widths are 12 bits. Parameter totals above 4095 are illegal.

Test Plan:
1. Defaults, rst held 5 cycles then released:
   - Edge 1: req=1, req_x=0, req_y=0.
   - Edge 3: de=1, x=0, y=0, frame_start=1.
   - All outputs at reset values while rst is high.
2. Defaults, one full line:
   - de high 640 cycles then low 160.
   - hsync low exactly for display h 656..751 (96 cycles), high otherwise.
   - x runs 0..639 then reads 0.
3. Defaults, full frame:
   - vsync low for lines 490–491 (1600 cycles), starting at h=0 of line 490.
   - de never high on lines 480..524.
   - frame_start period exactly 420000 cycles.
4. Lead alignment:
   - Record (req_x, req_y) on every req cycle.
   - They must equal (x, y) on de exactly 2 cycles later, for a full frame including the wrap from line 479 to line 0 of the next frame.
5. Mid-frame reset:
   - Pulse rst for 1 cycle at display position (300,200).
   - Next cycle: de=0, hsync=1, vsync=1.
   - Sequence then matches scenario 1 exactly.
6. Small parameters, exhaustive:
   - H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, HS_POL=VS_POL=1, REQ_LEAD=3.
   - Check every cycle of 3 frames against a reference model.
   - Confirms hsync high at h=5, vsync high on line 3, and req leading de by 3 across line and frame wrap.
